clkdiv_prog: RTL and testbench



---
 rtl/clkdiv_prog.sv | 139 +++++++++++++
 tb/tb_clkdiv_prog.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_prog.sv
// Programmable clock-enable divider: square or one-cycle-pulse output at clk/N,
// with a valid/ready loaded configuration that takes effect at a period boundary.
module clkdiv_prog #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DEFAULT_DIV  = 4,
  parameter int unsigned DEFAULT_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             mode_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             load_err,
  output logic             out,
  output logic             tick,
  output logic [WIDTH-1:0] cur_div
);

  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] HALF_RST = WIDTH'((DEFAULT_DIV + 1) >> 1);
  localparam logic             MODE_RST = 1'(DEFAULT_MODE);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO     = WIDTH'(0);

  // Active configuration; cur_div doubles as the active divisor register
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] half_q, half_nxt;
  logic             mode_q, mode_nxt;
  logic [WIDTH-1:0] div_nxt;

  // Pending configuration; load_ready low means a request is pending
  logic [WIDTH-1:0] pend_div, pend_div_nxt;
  logic             pend_mode, pend_mode_nxt;
  logic             ready_nxt;

  logic             out_nxt;
  logic             tick_nxt;
  logic             err_nxt;

  logic             last;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] pend_half;
  logic             pend_valid;
  logic             apply;
  logic             accept;
  logic             capture;
  logic             reject;

  // Output value for count c under divisor n, half-period h and mode m
  function automatic logic f_out(input logic [WIDTH-1:0] c,
                                 input logic [WIDTH-1:0] n,
                                 input logic [WIDTH-1:0] h,
                                 input logic             m);
    if (m) f_out = (c == n - ONE);
    else   f_out = (c < h);
  endfunction

  // Next-state logic
  always_comb begin
    cnt_nxt       = cnt;
    div_nxt       = cur_div;
    half_nxt      = half_q;
    mode_nxt      = mode_q;
    pend_div_nxt  = pend_div;
    pend_mode_nxt = pend_mode;
    ready_nxt     = load_ready;
    out_nxt       = out;
    tick_nxt      = 1'b0;
    err_nxt       = 1'b0;

    last       = (cnt == cur_div - ONE);
    cnt_inc    = last ? ZERO : cnt + ONE;
    // (N+1)>>1 needs one extra bit so N = 2^WIDTH-1 does not wrap
    pend_half  = WIDTH'(({1'b0, pend_div} + (WIDTH+1)'(1)) >> 1);
    pend_valid = !load_ready;
    apply      = pend_valid && (!en || last);
    accept     = load_valid && load_ready;
    capture    = accept && (div_in != ZERO);
    reject     = accept && (div_in == ZERO);

    if (apply) begin
      div_nxt   = pend_div;
      mode_nxt  = pend_mode;
      half_nxt  = pend_half;
      ready_nxt = 1'b1;
      if (en) begin
        cnt_nxt  = ZERO;
        out_nxt  = f_out(ZERO, pend_div, pend_half, pend_mode);
        tick_nxt = (pend_div == ONE);
      end else begin
        // Re-arm so the next enabled edge begins a fresh period
        cnt_nxt = pend_div - ONE;
        out_nxt = 1'b0;
      end
    end else if (en) begin
      cnt_nxt  = cnt_inc;
      out_nxt  = f_out(cnt_inc, cur_div, half_q, mode_q);
      tick_nxt = (cnt_inc == cur_div - ONE);
    end

    // Capture and apply never coincide: capture requires an empty pending slot
    if (capture) begin
      pend_div_nxt  = div_in;
      pend_mode_nxt = mode_in;
      ready_nxt     = 1'b0;
    end
    err_nxt = reject;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= DIV_RST - ONE;
      cur_div    <= DIV_RST;
      half_q     <= HALF_RST;
      mode_q     <= MODE_RST;
      pend_div   <= DIV_RST;
      pend_mode  <= MODE_RST;
      load_ready <= 1'b1;
      out        <= 1'b0;
      tick       <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      cur_div    <= div_nxt;
      half_q     <= half_nxt;
      mode_q     <= mode_nxt;
      pend_div   <= pend_div_nxt;
      pend_mode  <= pend_mode_nxt;
      load_ready <= ready_nxt;
      out        <= out_nxt;
      tick       <= tick_nxt;
      load_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_clkdiv_prog.sv
// Bench for clkdiv_prog: a per-cycle reference model fills a scoreboard queue,
// and each scenario task adds its own directed checks.
module tb_clkdiv_prog;

  localparam int unsigned W = 8;

  logic         Clk_tb = 1'b0;
  logic         reset;
  logic         en;
  logic [W-1:0] div_in;
  logic         mode_in;
  logic         load_valid;
  logic         d_ready;
  logic         d_err;
  logic         d_out;
  logic         d_tick;
  logic [W-1:0] d_cur_div;

  always #5 Clk_tb = ~Clk_tb;

  clkdiv_prog #(.WIDTH(W), .DEFAULT_DIV(4), .DEFAULT_MODE(0)) dut (
    .clk        (Clk_tb),
    .reset      (reset),
    .en         (en),
    .div_in     (div_in),
    .mode_in    (mode_in),
    .load_valid (load_valid),
    .load_ready (d_ready),
    .load_err   (d_err),
    .out        (d_out),
    .tick       (d_tick),
    .cur_div    (d_cur_div)
  );

  typedef struct packed {
    logic         out;
    logic         tick;
    logic [W-1:0] div;
    logic         ready;
    logic         err;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  int m_cnt, m_n, m_pd;
  bit m_mode, m_pm, m_pv, m_out, m_tick, m_err;
  bit m_live = 1'b0;

  function automatic bit mf(input int c, input int n, input bit mode);
    if (mode) return (c == n - 1);
    return (c < (n + 1) / 2);
  endfunction

  task automatic model_step();
    bit   last;
    bit   acc;
    bit   apply;
    int   nxt;
    obs_t e;
    if (reset) begin
      m_cnt = 3; m_n = 4; m_mode = 1'b0; m_pv = 1'b0;
      m_out = 1'b0; m_tick = 1'b0; m_err = 1'b0; m_live = 1'b1;
    end else if (m_live) begin
      last  = (m_cnt == m_n - 1);
      nxt   = last ? 0 : m_cnt + 1;
      acc   = load_valid && !m_pv;
      apply = m_pv && (!en || last);
      m_err  = acc && (div_in == '0);
      m_tick = 1'b0;
      if (apply) begin
        m_n = m_pd; m_mode = m_pm; m_pv = 1'b0;
        if (en) begin
          m_cnt = 0; m_out = mf(0, m_n, m_mode); m_tick = (m_n == 1);
        end else begin
          m_cnt = m_n - 1; m_out = 1'b0;
        end
      end else if (en) begin
        m_cnt = nxt; m_out = mf(nxt, m_n, m_mode); m_tick = (nxt == m_n - 1);
      end
      if (acc && div_in != '0) begin
        m_pd = int'(div_in); m_pm = mode_in; m_pv = 1'b1;
      end
    end
    if (m_live) begin
      e.out = m_out; e.tick = m_tick; e.div = W'(m_n); e.ready = !m_pv; e.err = m_err;
      exp_q.push_back(e);
    end
  endtask

  // One clock: model predicts, DUT steps, scoreboard entry is retired
  task automatic cyc();
    obs_t e;
    obs_t a;
    model_step();
    @(posedge Clk_tb);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.out = d_out; a.tick = d_tick; a.div = d_cur_div; a.ready = d_ready; a.err = d_err;
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL scoreboard t=%0t got out=%b tick=%b div=%0d rdy=%b err=%b want out=%b tick=%b div=%0d rdy=%b err=%b",
                 $time, a.out, a.tick, a.div, a.ready, a.err, e.out, e.tick, e.div, e.ready, e.err);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; load_valid = 1'b0; div_in = '0; mode_in = 1'b0;
    cyc(); cyc();
    vectors++; if (d_out !== 1'b0) begin miscompares++; $display("FAIL reset_out got %b want 0", d_out); end
    vectors++; if (d_tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick got %b want 0", d_tick); end
    vectors++; if (d_cur_div !== 8'd4) begin miscompares++; $display("FAIL reset_div got %0d want 4", d_cur_div); end
    vectors++; if (d_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", d_ready); end
    vectors++; if (d_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", d_err); end
  endtask

  task automatic test_default();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      vectors++; if (d_out !== (i % 4 < 2)) begin miscompares++; $display("FAIL default_out[%0d] got %b want %b", i, d_out, (i % 4 < 2)); end
      vectors++; if (d_tick !== (i % 4 == 3)) begin miscompares++; $display("FAIL default_tick[%0d] got %b want %b", i, d_tick, (i % 4 == 3)); end
    end
  endtask

  task automatic test_mid_load();
    cyc(); cyc();
    load_valid = 1'b1; div_in = 8'd5; mode_in = 1'b0;
    cyc();
    load_valid = 1'b0;
    vectors++; if (d_ready !== 1'b0) begin miscompares++; $display("FAIL midload_ready_low got %b want 0", d_ready); end
    vectors++; if (d_cur_div !== 8'd4) begin miscompares++; $display("FAIL midload_div_old got %0d want 4", d_cur_div); end
    cyc();
    vectors++; if (d_tick !== 1'b1) begin miscompares++; $display("FAIL midload_old_boundary got %b want 1", d_tick); end
    vectors++; if (d_ready !== 1'b0) begin miscompares++; $display("FAIL midload_ready_still_low got %b want 0", d_ready); end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc();
      else begin
        cyc();
        vectors++; if (d_ready !== 1'b1) begin miscompares++; $display("FAIL midload_ready_back got %b want 1", d_ready); end
      end
      vectors++; if (d_cur_div !== 8'd5) begin miscompares++; $display("FAIL midload_div_new got %0d want 5", d_cur_div); end
      vectors++; if (d_out !== (i % 5 < 3)) begin miscompares++; $display("FAIL midload_out[%0d] got %b want %b", i, d_out, (i % 5 < 3)); end
    end
  endtask

  task automatic test_pulse();
    int k;
    // Captured on the N=5 boundary edge, so it waits a full further period
    load_valid = 1'b1; div_in = 8'd3; mode_in = 1'b1;
    cyc();
    load_valid = 1'b0;
    k = 0;
    while (k < 8 && d_cur_div !== 8'd3) begin cyc(); k++; end
    vectors++; if (k != 5) begin miscompares++; $display("FAIL pulse_apply_latency got %0d want 5", k); end
    for (int i = 0; i < 9; i++) begin
      vectors++; if (d_out !== (i % 3 == 2)) begin miscompares++; $display("FAIL pulse_out[%0d] got %b want %b", i, d_out, (i % 3 == 2)); end
      vectors++; if (d_tick !== d_out) begin miscompares++; $display("FAIL pulse_tick_align[%0d] got tick=%b want %b", i, d_tick, d_out); end
      cyc();
    end
    load_valid = 1'b1; div_in = 8'd1; mode_in = 1'b1;
    cyc();
    load_valid = 1'b0;
    k = 0;
    while (k < 8 && d_cur_div !== 8'd1) begin cyc(); k++; end
    vectors++; if (d_cur_div !== 8'd1) begin miscompares++; $display("FAIL n1_apply got %0d want 1", d_cur_div); end
    for (int i = 0; i < 6; i++) begin
      vectors++; if ({d_out, d_tick} !== 2'b11) begin miscompares++; $display("FAIL n1_const[%0d] got %b%b want 11", i, d_out, d_tick); end
      cyc();
    end
  endtask

  task automatic test_enable_gating();
    int k;
    load_valid = 1'b1; div_in = 8'd8; mode_in = 1'b0;
    cyc();
    load_valid = 1'b0;
    k = 0;
    while (k < 8 && d_cur_div !== 8'd8) begin cyc(); k++; end
    vectors++; if (d_cur_div !== 8'd8) begin miscompares++; $display("FAIL gate_setup_div got %0d want 8", d_cur_div); end
    cyc(); cyc(); cyc();
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      vectors++; if ({d_out, d_tick} !== 2'b10) begin miscompares++; $display("FAIL gate_frozen[%0d] got out=%b tick=%b want out=1 tick=0", i, d_out, d_tick); end
    end
    en = 1'b1;
    cyc();
    vectors++; if (d_out !== 1'b0) begin miscompares++; $display("FAIL gate_resume_out got %b want 0", d_out); end
    cyc(); cyc(); cyc();
    vectors++; if (d_tick !== 1'b1) begin miscompares++; $display("FAIL gate_resume_tick got %b want 1", d_tick); end
    cyc();
    en = 1'b0; load_valid = 1'b1; div_in = 8'd6; mode_in = 1'b0;
    cyc();
    load_valid = 1'b0;
    vectors++; if (d_out !== 1'b1) begin miscompares++; $display("FAIL gate_capture_hold got %b want 1", d_out); end
    cyc();
    vectors++; if (d_cur_div !== 8'd6) begin miscompares++; $display("FAIL gate_apply_div got %0d want 6", d_cur_div); end
    vectors++; if ({d_out, d_tick} !== 2'b00) begin miscompares++; $display("FAIL gate_apply_out got out=%b tick=%b want 0 0", d_out, d_tick); end
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      vectors++; if (d_out !== (i % 6 < 3)) begin miscompares++; $display("FAIL gate_n6_out[%0d] got %b want %b", i, d_out, (i % 6 < 3)); end
      vectors++; if (d_tick !== (i % 6 == 5)) begin miscompares++; $display("FAIL gate_n6_tick[%0d] got %b want %b", i, d_tick, (i % 6 == 5)); end
    end
  endtask

  task automatic test_rejected();
    load_valid = 1'b1; div_in = 8'd0; mode_in = 1'b1;
    cyc();
    load_valid = 1'b0;
    vectors++; if (d_err !== 1'b1) begin miscompares++; $display("FAIL reject_err got %b want 1", d_err); end
    vectors++; if (d_ready !== 1'b1) begin miscompares++; $display("FAIL reject_ready got %b want 1", d_ready); end
    vectors++; if (d_cur_div !== 8'd6) begin miscompares++; $display("FAIL reject_div got %0d want 6", d_cur_div); end
    cyc();
    vectors++; if (d_err !== 1'b0) begin miscompares++; $display("FAIL reject_err_width got %b want 0", d_err); end
    for (int i = 0; i < 6; i++) cyc();
    vectors++; if (d_cur_div !== 8'd6) begin miscompares++; $display("FAIL reject_div_after got %0d want 6", d_cur_div); end
  endtask

  task automatic test_reset_pending();
    load_valid = 1'b1; div_in = 8'd7; mode_in = 1'b0;
    cyc();
    load_valid = 1'b0;
    vectors++; if (d_ready !== 1'b0) begin miscompares++; $display("FAIL rstpend_captured got %b want 0", d_ready); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    vectors++; if ({d_out, d_tick, d_ready} !== 3'b001) begin miscompares++; $display("FAIL rstpend_flags got out=%b tick=%b rdy=%b want 0 0 1", d_out, d_tick, d_ready); end
    vectors++; if (d_cur_div !== 8'd4) begin miscompares++; $display("FAIL rstpend_div got %0d want 4", d_cur_div); end
    for (int i = 0; i < 12; i++) begin
      cyc();
      vectors++; if (d_cur_div !== 8'd4) begin miscompares++; $display("FAIL rstpend_no_apply[%0d] got %0d want 4", i, d_cur_div); end
      vectors++; if (d_out !== (i % 4 < 2)) begin miscompares++; $display("FAIL rstpend_out[%0d] got %b want %b", i, d_out, (i % 4 < 2)); end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; load_valid = 1'b0; div_in = '0; mode_in = 1'b0;
    test_reset();
    test_default();
    test_mid_load();
    test_pulse();
    test_enable_gating();
    test_rejected();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
